// File: rtl/renkon_pkg.sv
// ============================================================================
// Module : renkon_pkg
// Brief  : Shared constants, line-buffer state encoding and window indexing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package renkon_pkg;

    localparam int DWIDTH  = 16;
    localparam int FSIZE   = 5;
    localparam int MAXIMG  = 32;
    localparam int IMGBITS = $clog2(MAXIMG + 1);

    typedef enum logic [1:0] {
        LB_IDLE   = 2'd0,
        LB_FILL   = 2'd1,
        LB_STREAM = 2'd2,
        LB_DONE   = 2'd3
    } lb_state_e;

    // Flat element index of window row i, column j.
    function automatic int win_idx(input int i, input int j);
        return i * FSIZE + j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/renkon_linebuf_if.sv
// ============================================================================
// Module : renkon_linebuf_if
// Brief  : Pixel-stream and window-output bundle of the line buffer.
//          Carries win_count when RENKON_LINEBUF_COUNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface renkon_linebuf_if;
    import renkon_pkg::*;

    logic [IMGBITS-1:0]            img_size;
    logic                          buf_req;
    logic                          in_valid;
    logic [DWIDTH-1:0]             buf_input;
    logic                          out_valid;
    logic [FSIZE*FSIZE*DWIDTH-1:0] buf_output;
    logic                          busy;
    logic                          done;
    logic                          err;
`ifdef RENKON_LINEBUF_COUNT_EN
    logic [2*IMGBITS-1:0]          win_count;
`endif

    modport master (
        output img_size, buf_req, in_valid, buf_input,
        input  out_valid, buf_output, busy, done, err
`ifdef RENKON_LINEBUF_COUNT_EN
        , input win_count
`endif
    );

    modport slave (
        input  img_size, buf_req, in_valid, buf_input,
        output out_valid, buf_output, busy, done, err
`ifdef RENKON_LINEBUF_COUNT_EN
        , output win_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/renkon_linebuf_row.sv
// ============================================================================
// Module : renkon_linebuf_row
// Brief  : Single-row delay line, MAXIMG deep, tapped at runtime length i_len.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module renkon_linebuf_row
    import renkon_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_en,
    input  wire logic [IMGBITS-1:0] i_len,
    input  wire logic [DWIDTH-1:0]  i_din,
    output logic      [DWIDTH-1:0]  o_tap
);

    localparam int AW = $clog2(MAXIMG);

    logic [MAXIMG-1:0][DWIDTH-1:0] r_mem;
    logic [AW-1:0]                 w_idx;

    // Tap returns the sample pushed i_len enables ago, i.e. the pixel one row up.
    assign w_idx = AW'(i_len - IMGBITS'(1));
    assign o_tap = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_en) begin
            r_mem <= {r_mem[MAXIMG-2:0], i_din};
        end
    end

endmodule

`default_nettype wire

// File: rtl/renkon_linebuf.sv
// ============================================================================
// Module : renkon_linebuf
// Brief  : FSIZE x FSIZE stride-1 sliding-window line buffer for raster maps.
//          Optional win_count output via RENKON_LINEBUF_COUNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module renkon_linebuf
    import renkon_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    renkon_linebuf_if.slave bus
);

    localparam logic [1:0] S_IDLE   = LB_IDLE;
    localparam logic [1:0] S_FILL   = LB_FILL;
    localparam logic [1:0] S_STREAM = LB_STREAM;
    localparam logic [1:0] S_DONE   = LB_DONE;

    logic [1:0]                    r_state;
    logic [IMGBITS-1:0]            r_size;
    logic [IMGBITS-1:0]            r_row;
    logic [IMGBITS-1:0]            r_col;
    logic [FSIZE-1:0][FSIZE-1:0][DWIDTH-1:0] r_win;
    logic                          r_out_valid;
    logic [FSIZE*FSIZE*DWIDTH-1:0] r_out;
    logic                          r_err;

    logic                          w_accept;
    logic                          w_size_ok;
    logic                          w_req_ok;
    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_win_ok;
    logic [DWIDTH-1:0]             w_tap [FSIZE-1];
    logic [DWIDTH-1:0]             w_col [FSIZE];
    logic [FSIZE-1:0][FSIZE-1:0][DWIDTH-1:0] w_win_next;
    logic [FSIZE*FSIZE*DWIDTH-1:0] w_pack;

    assign w_accept   = bus.in_valid && ((r_state == S_FILL) || (r_state == S_STREAM));
    assign w_size_ok  = (bus.img_size >= IMGBITS'(FSIZE)) && (bus.img_size <= IMGBITS'(MAXIMG));
    assign w_req_ok   = bus.buf_req && (r_state == S_IDLE) && w_size_ok;
    assign w_col_last = (r_col == r_size - IMGBITS'(1));
    assign w_row_last = (r_row == r_size - IMGBITS'(1));
    assign w_win_ok   = (r_row >= IMGBITS'(FSIZE-1)) && (r_col >= IMGBITS'(FSIZE-1));

    // Row FIFOs are chained: FIFO k delivers the pixel k+1 rows above the input.
    assign w_col[FSIZE-1] = bus.buf_input;
    for (genvar k = 0; k < FSIZE-1; k++) begin : g_rows
        logic [DWIDTH-1:0] w_din;
        if (k == 0) begin : g_head
            assign w_din = bus.buf_input;
        end else begin : g_chain
            assign w_din = w_tap[k-1];
        end
        renkon_linebuf_row u_row (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_accept),
            .i_len (r_size),
            .i_din (w_din),
            .o_tap (w_tap[k])
        );
        assign w_col[FSIZE-2-k] = w_tap[k];
    end

    always_comb begin
        w_win_next = r_win;
        w_pack     = '0;
        for (int i = 0; i < FSIZE; i++) begin
            for (int j = 0; j < FSIZE-1; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
            w_win_next[i][FSIZE-1] = w_col[i];
        end
        for (int i = 0; i < FSIZE; i++) begin
            for (int j = 0; j < FSIZE; j++) begin
                w_pack[win_idx(i, j)*DWIDTH +: DWIDTH] = w_win_next[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_accept && w_win_ok;
            r_err       <= bus.buf_req && (r_state == S_IDLE) && !w_size_ok;

            if (w_accept) begin
                r_win <= w_win_next;
                if (w_win_ok) begin
                    r_out <= w_pack;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + IMGBITS'(1);
                end else begin
                    r_col <= r_col + IMGBITS'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req_ok) begin
                        r_size  <= bus.img_size;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept && (r_row == IMGBITS'(FSIZE-1)) && (r_col == '0)) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_accept && w_row_last && w_col_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.buf_output = r_out;
    assign bus.busy       = (r_state == S_FILL) || (r_state == S_STREAM);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = r_err;

`ifdef RENKON_LINEBUF_COUNT_EN
    logic [2*IMGBITS-1:0] r_win_count;

    always_ff @(posedge clk) begin
        if (rst || w_req_ok) begin
            r_win_count <= '0;
        end else if (r_out_valid) begin
            r_win_count <= r_win_count + (2*IMGBITS)'(1);
        end
    end

    assign bus.win_count = r_win_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_renkon_linebuf.sv
// ============================================================================
// Module : tb_renkon_linebuf
// Brief  : Directed, table-driven bench for renkon_linebuf.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_renkon_linebuf;
    import renkon_pkg::*;

    logic clk = 1'b0;
    logic rst;

    renkon_linebuf_if bus ();

    renkon_linebuf u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int size;
        bit bub;
        int nwin;
        int f0;
        int f24;
        int l24;
        int first_at;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int elem(input int k);
        logic signed [DWIDTH-1:0] e;
        e = bus.buf_output[k*DWIDTH +: DWIDTH];
        return int'(e);
    endfunction

    // Starts a map and feeds npix pixels (value size*r+c); req_at >= 0 issues a
    // buf_req while busy at that pixel index.
    task automatic feed(input int size, input bit bub, input int npix, input int req_at,
                        output int nwin, output int first0, output int first24,
                        output int last24, output int first_at, output bit saw_done);
        int n;
        int nw;
        int bad;
        int ex;
        bit v;
        n = 0; nw = size - FSIZE + 1;
        nwin = 0; first0 = -1; first24 = -1; last24 = -1; first_at = -1; saw_done = 1'b0;
        bus.img_size = IMGBITS'(size);
        bus.buf_req  = 1'b1;
        tick();
        bus.buf_req  = 1'b0;
        check("busy_after_req", bus.busy, 1);
`ifdef RENKON_LINEBUF_COUNT_EN
        check("win_count_cleared", bus.win_count, 0);
`endif
        for (int cyc = 0; cyc < 2*npix + 20; cyc++) begin
            v = (n < npix) && (!bub || (cyc % 2 == 0));
            bus.in_valid  = v;
            bus.buf_input = v ? DWIDTH'(size*(n/size) + n%size) : 16'h7bad;
            bus.buf_req   = (req_at >= 0) && (n == req_at) && v;
            bus.img_size  = bus.buf_req ? IMGBITS'(5) : IMGBITS'(size);
            tick();
            if (v) n++;
            if (bus.buf_req) begin
                bus.buf_req = 1'b0;
                check("busy_req_no_err", bus.err, 0);
                check("busy_req_still_busy", bus.busy, 1);
            end
            if (!v) begin
                check("out_valid_in_gap", bus.out_valid, 0);
            end else if (bus.out_valid) begin
                if (nwin == 0) begin
                    first0 = elem(0); first24 = elem(24); first_at = n - 1;
                end
                last24 = elem(24);
                bad = 0;
                for (int k = 0; k < FSIZE*FSIZE; k++) begin
                    ex = size*(nwin/nw + k/FSIZE) + nwin%nw + k%FSIZE;
                    if (elem(k) != ex) bad++;
                end
                check("window_elems", bad, 0);
                nwin++;
            end
            if (bus.done) begin
                saw_done = 1'b1;
                check("done_with_last_out", bus.out_valid, 1);
                break;
            end
            if (n >= npix && !v) break;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int nwin, f0, f24, l24, fat;
        bit sd;

        vecs[0] = '{8, 1'b0, 16, 0, 36, 63, 36};
        vecs[1] = '{5, 1'b0,  1, 0, 24, 24, 24};
        vecs[2] = '{8, 1'b1, 16, 0, 36, 63, 36};
        vecs[3] = '{7, 1'b1,  9, 0, 32, 48, 32};
        vecs[4] = '{6, 1'b0,  4, 0, 28, 35, 28};

        rst = 1'b1;
        bus.img_size = '0; bus.buf_req = 1'b0; bus.in_valid = 1'b0; bus.buf_input = '0;
        tick(); tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_buf_output", (bus.buf_output == '0), 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) begin
            feed(vecs[t].size, vecs[t].bub, vecs[t].size*vecs[t].size, -1,
                 nwin, f0, f24, l24, fat, sd);
            check("saw_done", sd, 1);
            check("num_windows", nwin, vecs[t].nwin);
            check("first_elem0", f0, vecs[t].f0);
            check("first_elem24", f24, vecs[t].f24);
            check("last_elem24", l24, vecs[t].l24);
            check("first_window_at", fat, vecs[t].first_at);
            tick();
            check("done_one_cycle", bus.done, 0);
            check("busy_after_done", bus.busy, 0);
            check("out_valid_after_done", bus.out_valid, 0);
            check("output_holds", elem(24), vecs[t].l24);
`ifdef RENKON_LINEBUF_COUNT_EN
            check("win_count_total", bus.win_count, vecs[t].nwin);
`endif
            tick();
        end

        // Illegal sizes: err pulse, stay idle, following pixels dropped.
        for (int s = 0; s < 2; s++) begin
            bus.img_size = (s == 0) ? IMGBITS'(4) : IMGBITS'(33);
            bus.buf_req  = 1'b1;
            tick();
            bus.buf_req  = 1'b0;
            check("illegal_err", bus.err, 1);
            check("illegal_busy", bus.busy, 0);
            bus.in_valid = 1'b1; bus.buf_input = 16'h0055;
            tick();
            check("illegal_err_pulse", bus.err, 0);
            for (int c = 0; c < 6; c++) begin
                tick();
                check("idle_drop_out_valid", bus.out_valid, 0);
                check("idle_drop_busy", bus.busy, 0);
            end
            bus.in_valid = 1'b0;
            tick();
        end

        // Abort an 8x8 map after input 40 with a busy request along the way.
        feed(8, 1'b0, 41, 20, nwin, f0, f24, l24, fat, sd);
        check("abort_no_done", sd, 0);
        check("abort_windows", nwin, 4);
        rst = 1'b1;
        tick();
        check("abort_rst_done", bus.done, 0);
        check("abort_rst_busy", bus.busy, 0);
        check("abort_rst_out", (bus.buf_output == '0), 1);
        rst = 1'b0;
        tick();
        check("abort_post_done", bus.done, 0);
        feed(6, 1'b0, 36, -1, nwin, f0, f24, l24, fat, sd);
        check("restart_done", sd, 1);
        check("restart_windows", nwin, 4);
        check("restart_elem0", f0, 0);
        check("restart_elem24", f24, 28);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
